// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per clock, with an optional one-step path for divide-by-zero and signed overflow.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start_i; outputs hold the last result
// S_BUSY | one radix-2 step per edge, busy_o high, counter counts down
// S_DONE | done_o high for one cycle; may accept the next operation
module md_unit #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int FAST_SPECIAL = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] rd_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN:0]     acc_q;
    logic [XLEN:0]       rem_q;
    logic [XLEN-1:0]     opa_q;
    logic [XLEN-1:0]     opb_q;
    logic [2:0]          f3_q;
    logic [REG_AW-1:0]   rd_q;
    logic                sa_q;
    logic                sb_q;
    logic                divz_q;
    logic                ovf_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     res_q;
    logic [REG_AW-1:0]   rdo_q;

    logic                a_sgn;
    logic                b_sgn;
    logic                sa_d;
    logic                sb_d;
    logic                is_div_d;
    logic                divz_d;
    logic                ovf_d;
    logic                fast_d;
    logic                accept;
    logic [XLEN-1:0]     abs_a_d;
    logic [XLEN-1:0]     abs_b_d;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3_i)
            3'd1, 3'd4, 3'd6: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'd2:    a_sgn = 1'b1;
            default: ;
        endcase
        sa_d     = a_sgn & rs1_i[XLEN-1];
        sb_d     = b_sgn & rs2_i[XLEN-1];
        abs_a_d  = sa_d ? -rs1_i : rs1_i;
        abs_b_d  = sb_d ? -rs2_i : rs2_i;
        is_div_d = funct3_i[2];
        divz_d   = is_div_d && (rs2_i == '0);
        ovf_d    = is_div_d && !funct3_i[0] && (rs1_i == MIN_V) && (rs2_i == '1);
        fast_d   = (FAST_SPECIAL != 0) && (divz_d || ovf_d);
        accept   = start_i && !flush_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    logic [XLEN:0]       mul_sum;
    logic [XLEN+1:0]     div_shift;
    logic [XLEN+1:0]     div_diff;
    logic                div_ge;
    logic [XLEN:0]       rem_nx;
    logic [XLEN-1:0]     quo_nx;
    logic [2*XLEN:0]     acc_nx;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     a_orig;
    logic [XLEN-1:0]     res_nx;

    always_comb begin
        // acc_q[2*XLEN] is always 0 between steps; it is the carry slot of the add.
        mul_sum   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {2'b00, opb_q};
        div_ge    = ~div_diff[XLEN+1];
        rem_nx    = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
        quo_nx    = {acc_q[XLEN-2:0], div_ge};
        if (f3_q[2])
            acc_nx = {{(XLEN+1){1'b0}}, quo_nx};
        else
            acc_nx = {1'b0, mul_sum, acc_q[XLEN-1:1]};

        prod_s = (sa_q ^ sb_q) ? -acc_nx[2*XLEN-1:0] : acc_nx[2*XLEN-1:0];
        quo_s  = (sa_q ^ sb_q) ? -quo_nx : quo_nx;
        rem_s  = sa_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        a_orig = sa_q ? -opa_q : opa_q;
        // Special cases override whatever the iteration produced (fast path runs only one step).
        if (divz_q) begin
            quo_s = '1;
            rem_s = a_orig;
        end else if (ovf_q) begin
            quo_s = MIN_V;
            rem_s = '0;
        end

        case (f3_q)
            3'd0:             res_nx = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: res_nx = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       res_nx = quo_s;
            default:          res_nx = rem_s;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            divz_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            rdo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q <= S_BUSY;
                busy_q  <= 1'b1;
                cnt_q   <= fast_d ? CW'(1) : CW'(XLEN);
                acc_q   <= {{(XLEN+1){1'b0}}, (is_div_d ? abs_a_d : abs_b_d)};
                rem_q   <= '0;
                opa_q   <= abs_a_d;
                opb_q   <= abs_b_d;
                f3_q    <= funct3_i;
                rd_q    <= rd_i;
                sa_q    <= sa_d;
                sb_q    <= sb_d;
                divz_q  <= divz_d;
                ovf_q   <= ovf_d;
            end else begin
                case (state_q)
                    S_BUSY: begin
                        if (flush_i) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            acc_q <= acc_nx;
                            if (f3_q[2])
                                rem_q <= rem_nx;
                            cnt_q <= cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                res_q   <= res_nx;
                                rdo_q   <= rd_q;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = res_q;
    assign rd_o     = rdo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised iterative multiply/divide execute unit for the RV32M extension in the 5-stage pipeline.
- Sits in EX beside the ALU:
  - accepts one operation from ID_EX;
  - holds busy_o high while it iterates, so the hazard unit freezes PC, IF_ID and ID_EX;
  - returns a result with its destination tag for EX_MEM.
- Generalised in operand width; optional single-cycle fast path for the divide special cases.

Parameters:
XLEN, 32, operand/result width in bits (>=8, even)
REG_AW, 5, destination register tag width
FAST_SPECIAL, 1, 1 = divide-by-zero and signed overflow complete in 1 iteration cycle; 0 = full XLEN iterations

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  operation request; sampled only when accept condition holds
flush_i  input  1  abort in-flight operation (branch taken / pipeline flush)
funct3_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  input  XLEN  operand A (dividend / multiplicand)
rs2_i  input  XLEN  operand B (divisor / multiplier)
rd_i  input  REG_AW  destination tag
busy_o  output  1  high in BUSY; hazard stall request
done_o  output  1  one-cycle result-valid pulse
result_o  output  XLEN  result; held until next accepted start
rd_o  output  REG_AW  tag of result_o; held with result_o

Behaviour:
- Reset (rst_i=0, immediate, no clock needed):
  - state IDLE, counter 0;
  - busy_o=0, done_o=0, result_o=0, rd_o=0;
  - all internal operand/accumulator registers 0.
- States:
  - IDLE: accept start_i when flush_i=0. Latch |A|, |B|, result sign flags, funct3, rd_i. Counter=XLEN. Go to BUSY.
  - BUSY:
    - Perform one radix-2 step per edge: shift-add for multiply into a 2*XLEN accumulator; restoring subtract for divide.
    - Decrement counter; at the step where the counter reaches 0, go to DONE.
    - start_i is ignored.
  - DONE:
    - done_o=1; result_o/rd_o valid.
    - Next edge: go to BUSY if start_i=1 and flush_i=0 (back-to-back accept), else go to IDLE.
- Latency: start accepted at edge t0 → done_o high during the cycle after edge t(XLEN), i.e. XLEN+1 cycles.
- busy_o: high from t0 until edge t(XLEN).
- Signed handling:
  - Operands are converted to magnitude before iteration: MULH/DIV/REM both signed, MULHSU only A.
  - Product is negated over the full 2*XLEN width if the signs differ.
  - Quotient sign = signA XOR signB; remainder sign = signA.
- Result select:
  - MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2XLEN-1:XLEN].
  - DIV/DIVU = quotient; REM/REMU = remainder.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (A=MIN, B=-1): quotient = MIN, remainder = 0.
  - With FAST_SPECIAL=1, both are detected at accept and the unit goes to BUSY for one edge then DONE, so done_o appears 2 cycles after start.
- flush_i:
  - Highest synchronous priority. From BUSY or DONE, the next edge goes to IDLE with done_o=0 and no start accepted.
  - result_o/rd_o keep their previous values.
- Simultaneous start_i and flush_i: start is dropped.
- Async reset mid-operation: outputs clear immediately; no done_o follows.
- Width rules:
  - Accumulator is 2*XLEN+1 bits (carry).
  - Divide remainder register is XLEN+1 bits.
  - Counter is clog2(XLEN+1) bits.

Test Plan:
- XLEN=32, MUL, rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → done_o pulses exactly 33 cycles after accept; result_o=0xFFFFFFEB, rd_o=5; busy_o high for 32 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV -7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0. With FAST_SPECIAL=1, done_o 2 cycles after accept; with 0, 33 cycles.
- Back-to-back: start_i held high with a new op while done_o=1 → second op accepted that edge; second done_o exactly 33 cycles later; no idle cycle between.
- flush_i at iteration 10 of a DIV → busy_o low next cycle, done_o never asserts, result_o unchanged. Then rst_i pulled low mid-MUL → busy_o, done_o, result_o, rd_o all 0 before the next clock edge.
